// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor.
// Processes DIGIT bits per clock, LSB slice first, with the slice carry held
// in a register between cycles. A result of WIDTH bits therefore takes
// WIDTH/DIGIT clock edges after the request is accepted. A valid/ready
// handshake is used on both the request and the result side.
module serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // Guarded divisor so that a bad DIGIT reports cleanly instead of
    // dividing by zero while the parameters are being checked.
    localparam int DIGIT_SAFE = (DIGIT < 1) ? 1 : DIGIT;
    localparam int N          = WIDTH / DIGIT_SAFE;
    localparam int CW         = (N > 1) ? $clog2(N) : 1;

    generate
        if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT_SAFE) != 0)) begin : g_bad_params
            $error("serial_addsub: WIDTH must be >= 2, DIGIT >= 1 and DIGIT must divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg;
    logic [WIDTH-1:0]  a_reg;       // operand A as latched at accept
    logic [WIDTH-1:0]  b_reg;       // effective operand B' (already inverted for subtract)
    logic              carry_reg;   // carry between slices
    logic [CW-1:0]     cnt_reg;     // index of the slice processed on the next CALC edge
    logic [WIDTH-1:0]  sum_reg;
    logic              cout_reg;
    logic              ovf_reg;

    logic [31:0]       base;
    logic [DIGIT-1:0]  a_slice;
    logic [DIGIT-1:0]  b_slice;
    logic [DIGIT:0]    slice_res;
    logic              slice_ovf;
    logic              last_slice;

    assign base       = 32'(cnt_reg) * 32'(DIGIT);
    assign a_slice    = a_reg[base +: DIGIT];
    assign b_slice    = b_reg[base +: DIGIT];
    assign last_slice = (cnt_reg == CW'(N - 1));

    // One DIGIT-wide ripple add of the current slice plus the stored carry.
    always_comb begin
        slice_res = {1'b0, a_slice} + {1'b0, b_slice} + {{DIGIT{1'b0}}, carry_reg};
        // Carry into the slice MSB equals a ^ b ^ s at that bit; XOR with the
        // carry out gives the signed overflow when this is the top slice.
        slice_ovf = a_slice[DIGIT-1] ^ b_slice[DIGIT-1] ^ slice_res[DIGIT-1] ^ slice_res[DIGIT];
    end

    // Control FSM and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= sub ? ~b : b;
                        carry_reg <= sub ? ~cin : cin;
                        cnt_reg   <= '0;
                        state_reg <= CALC;
                    end
                end
                CALC: begin
                    sum_reg[base +: DIGIT] <= slice_res[DIGIT-1:0];
                    carry_reg              <= slice_res[DIGIT];
                    // Overwritten every slice; the top slice leaves the final values.
                    cout_reg               <= slice_res[DIGIT];
                    ovf_reg                <= slice_ovf;
                    if (last_slice) begin
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed-vector bench for serial_addsub at WIDTH=16, DIGIT=4.
module tb_serial_addsub;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int LAT   = WIDTH / DIGIT;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int checks_cnt;
    int fail_cnt;

    serial_addsub #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any mismatch.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a request, wait for the accept edge, then for out_valid; returns latency.
    task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                            input logic ts, output int lat);
        @(negedge clk);
        a        = ta;
        b        = tb_;
        cin      = tc;
        sub      = ts;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    // Consume the result and confirm the block is back in IDLE.
    task automatic finish_op(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_val({tag, ".idle_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                          input logic tc, input logic ts, input logic [15:0] es,
                          input logic ec, input logic eo);
        int lat;
        start_op(ta, tb_, tc, ts, lat);
        check_val({tag, ".lat"}, 32'(lat), 32'(LAT));
        check_val({tag, ".sum"}, 32'(sum), 32'(es));
        check_val({tag, ".cout"}, 32'(cout), 32'(ec));
        check_val({tag, ".ovf"}, 32'(ovf), 32'(eo));
        $display("op %s a=%h b=%h cin=%0b sub=%0b -> sum=%h cout=%0b ovf=%0b lat=%0d",
                 tag, ta, tb_, tc, ts, sum, cout, ovf, lat);
        finish_op(tag);
    endtask

    initial begin
        int lat;
        logic [15:0] held_sum;
        logic        held_cout;
        logic        held_ovf;

        checks_cnt = 0;
        fail_cnt   = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        a          = '0;
        b          = '0;
        cin        = 1'b0;
        sub        = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst.in_ready", 32'(in_ready), 32'd1);
        check_val("rst.out_valid", 32'(out_valid), 32'd0);
        check_val("rst.sum", 32'(sum), 32'd0);
        check_val("rst.cout", 32'(cout), 32'd0);
        check_val("rst.ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add_cin",   16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);
        run_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_op("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_borrow",16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0);

        // Backpressure: hold the result while inputs churn and in_valid stays high.
        start_op(16'h00FF, 16'h0F01, 1'b0, 1'b0, lat);
        check_val("bp.lat", 32'(lat), 32'(LAT));
        check_val("bp.sum", 32'(sum), 32'h1000);
        held_sum  = sum;
        held_cout = cout;
        held_ovf  = ovf;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a        = (i % 2 == 0) ? 16'hAAAA : 16'h5555;
            b        = ~a;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check_val("bp.hold_sum", 32'(sum), 32'(held_sum));
            check_val("bp.hold_flags", {30'd0, cout, ovf}, {30'd0, held_cout, held_ovf});
            check_val("bp.in_ready", 32'(in_ready), 32'd0);
            check_val("bp.out_valid", 32'(out_valid), 32'd1);
        end
        $display("op bp held sum=%h for 10 cycles", sum);
        // Release: handshake edge returns to IDLE, next edge accepts the new request.
        @(negedge clk);
        out_ready = 1'b1;
        a         = 16'hA5A5;
        b         = 16'h5A5A;
        cin       = 1'b0;
        sub       = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_val("b2b.idle", 32'(in_ready), 32'd1);
        check_val("b2b.out_valid_low", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_val("b2b.accepted", 32'(in_ready), 32'd0);
        lat = 0;
        for (int i = 2; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        check_val("b2b.lat", 32'(lat), 32'(LAT + 1));
        check_val("b2b.sum", 32'(sum), 32'h4B4B);
        check_val("b2b.cout", 32'(cout), 32'd1);
        check_val("b2b.ovf", 32'(ovf), 32'd1);
        $display("op b2b a=a5a5 b=5a5a sub -> sum=%h cout=%0b ovf=%0b", sum, cout, ovf);
        finish_op("b2b");

        // Reset in the second CALC cycle must abort and leave no residue.
        @(negedge clk);
        a        = 16'hFFFF;
        b        = 16'hFFFF;
        cin      = 1'b1;
        sub      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("abort.in_ready", 32'(in_ready), 32'd1);
        check_val("abort.out_valid", 32'(out_valid), 32'd0);
        check_val("abort.sum", 32'(sum), 32'd0);
        check_val("abort.cout", 32'(cout), 32'd0);
        $display("op abort reset during CALC");
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
